// File: rtl/id_scoreboard_pkg.sv
// Shared sizing for the ID-stage register scoreboard.
// Holds register-file geometry and the width of the outstanding-write total.
package id_scoreboard_pkg;

    localparam int REG_INDEX_SIZE  = 5;
    localparam int NUM_REGS        = 1 << REG_INDEX_SIZE;
    localparam int SB_PENDING_SIZE = 7;

endpackage

// File: rtl/sb_entry.sv
// One scoreboard counter: outstanding long-latency writes to a single register.
// busy/full are reported after the same-cycle retire bypass.
module sb_entry #(
    parameter int SB_CNT_SIZE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic dec_i,
    output logic busy_o,
    output logic full_o,
    output logic underflow_o,
    output logic overflow_o
);

    localparam logic [SB_CNT_SIZE-1:0] CNT_MAX = '1;

    logic [SB_CNT_SIZE-1:0] cnt_q;
    logic [SB_CNT_SIZE-1:0] cnt_d;
    logic [SB_CNT_SIZE-1:0] eff;
    logic                   dec_ok;

    // A retire against an empty counter is an error and is dropped.
    assign underflow_o = dec_i & (cnt_q == '0);
    assign dec_ok      = dec_i & ~underflow_o;
    assign eff         = cnt_q - {{(SB_CNT_SIZE-1){1'b0}}, dec_ok};
    assign busy_o      = (eff != '0);
    assign full_o      = (eff == CNT_MAX);
    assign overflow_o  = inc_i & full_o;

    // NOTE: give every always_comb output a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = eff;
        if (inc_i && !overflow_o) begin
            cnt_d = eff + 1'b1;
        end
    end

    // NOTE: state uses non-blocking assignments; the async reset sits in the sensitivity list.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/id_scoreboard.sv
// ID-stage register scoreboard: stalls readers of registers with unretired
// long-latency writes and issuers that would over-subscribe a register's counter.
module id_scoreboard
    import id_scoreboard_pkg::*;
#(
    parameter int SB_CNT_SIZE = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [REG_INDEX_SIZE-1:0]  id_rs1_index_i,
    input  logic                       id_rs1_ren_i,
    input  logic [REG_INDEX_SIZE-1:0]  id_rs2_index_i,
    input  logic                       id_rs2_ren_i,
    input  logic [REG_INDEX_SIZE-1:0]  id_rd_index_i,
    input  logic                       id_rd_wen_i,
    input  logic                       id_long_i,
    input  logic                       id_issue_i,
    input  logic                       retire_valid_i,
    input  logic [REG_INDEX_SIZE-1:0]  retire_rd_index_i,
    output logic                       stall_o,
    output logic                       rs1_busy_o,
    output logic                       rs2_busy_o,
    output logic [SB_PENDING_SIZE-1:0] pending_cnt_o,
    output logic                       err_o
);

    logic [NUM_REGS-1:0] inc_vec;
    logic [NUM_REGS-1:0] dec_vec;
    logic [NUM_REGS-1:0] busy_vec;
    logic [NUM_REGS-1:0] full_vec;
    logic [NUM_REGS-1:0] unf_vec;
    logic [NUM_REGS-1:0] ovf_vec;

    logic                       acc_req;
    logic                       full_stall;
    logic                       acc;
    logic                       retire_ok;
    logic [SB_PENDING_SIZE-1:0] pending_q;
    logic [SB_PENDING_SIZE-1:0] pending_d;
    logic                       err_q;
    logic                       err_d;

    // x0 has no counter: never busy or full, and any retire to it is an error.
    assign busy_vec[0] = 1'b0;
    assign full_vec[0] = 1'b0;
    assign unf_vec[0]  = dec_vec[0];
    assign ovf_vec[0]  = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
        sb_entry #(
            .SB_CNT_SIZE (SB_CNT_SIZE)
        ) u_entry (
            .clk         (clk),
            .rst         (rst),
            .inc_i       (inc_vec[r]),
            .dec_i       (dec_vec[r]),
            .busy_o      (busy_vec[r]),
            .full_o      (full_vec[r]),
            .underflow_o (unf_vec[r]),
            .overflow_o  (ovf_vec[r])
        );
    end

    assign acc_req    = id_long_i & id_rd_wen_i & (id_rd_index_i != '0);
    assign rs1_busy_o = id_rs1_ren_i & busy_vec[id_rs1_index_i];
    assign rs2_busy_o = id_rs2_ren_i & busy_vec[id_rs2_index_i];
    assign full_stall = acc_req & full_vec[id_rd_index_i];
    assign stall_o    = id_issue_i & (rs1_busy_o | rs2_busy_o | full_stall);
    assign acc        = id_issue_i & ~stall_o & acc_req;
    assign retire_ok  = retire_valid_i & ~unf_vec[retire_rd_index_i];

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        inc_vec[id_rd_index_i]     = acc;
        dec_vec[retire_rd_index_i] = retire_valid_i;
    end

    assign pending_d = pending_q + SB_PENDING_SIZE'(acc) - SB_PENDING_SIZE'(retire_ok);
    assign err_d     = err_q | (|unf_vec) | (|ovf_vec);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    assign pending_cnt_o = pending_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_id_scoreboard.sv
// Self-checking bench for id_scoreboard: directed scenarios plus randomized
// traffic, all checked against a per-register count model.
module tb_id_scoreboard;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] rs1 = '0, rs2 = '0, rd = '0, rrd = '0;
    logic       r1en = 1'b0, r2en = 1'b0, wen = 1'b0, lng = 1'b0, iss = 1'b0, rv = 1'b0;
    logic       stall, b1, b2, err;
    logic [6:0] pend;

    int m_cnt [32];
    int m_pend;
    bit m_err;
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    id_scoreboard #(.SB_CNT_SIZE(2)) dut (
        .clk               (clk),
        .rst               (rst),
        .id_rs1_index_i    (rs1),
        .id_rs1_ren_i      (r1en),
        .id_rs2_index_i    (rs2),
        .id_rs2_ren_i      (r2en),
        .id_rd_index_i     (rd),
        .id_rd_wen_i       (wen),
        .id_long_i         (lng),
        .id_issue_i        (iss),
        .retire_valid_i    (rv),
        .retire_rd_index_i (rrd),
        .stall_o           (stall),
        .rs1_busy_o        (b1),
        .rs2_busy_o        (b2),
        .pending_cnt_o     (pend),
        .err_o             (err)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_pend = 0;
        m_err  = 1'b0;
    endtask

    task automatic drive(input bit i_iss, input bit i_lng, input bit i_wen, input int i_rd,
                         input bit i_r1en, input int i_rs1, input bit i_r2en, input int i_rs2,
                         input bit i_rv, input int i_rrd);
        iss = i_iss; lng = i_lng; wen = i_wen; rd = 5'(i_rd);
        r1en = i_r1en; rs1 = 5'(i_rs1); r2en = i_r2en; rs2 = 5'(i_rs2);
        rv = i_rv; rrd = 5'(i_rrd);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Samples at the falling edge, checks against the model, then applies the model update at the rising edge.
    task automatic step();
        bit rok, e1, e2, fs, st, acc;
        int eff_r1, eff_r2, eff_rd;
        @(negedge clk);
        rok    = rv && rrd != 0 && m_cnt[rrd] > 0;
        eff_r1 = m_cnt[rs1] - ((rok && rrd == rs1) ? 1 : 0);
        eff_r2 = m_cnt[rs2] - ((rok && rrd == rs2) ? 1 : 0);
        eff_rd = m_cnt[rd]  - ((rok && rrd == rd)  ? 1 : 0);
        e1  = r1en && rs1 != 0 && eff_r1 != 0;
        e2  = r2en && rs2 != 0 && eff_r2 != 0;
        fs  = lng && wen && rd != 0 && eff_rd == 3;
        st  = iss && (e1 || e2 || fs);
        acc = iss && !st && lng && wen && rd != 0;
        check("stall", int'(stall), int'(st));
        check("rs1_busy", int'(b1), int'(e1));
        check("rs2_busy", int'(b2), int'(e2));
        check("pending", int'(pend), m_pend);
        check("err", int'(err), int'(m_err));
        @(posedge clk);
        if (rok) begin
            m_cnt[rrd]--;
            m_pend--;
        end else if (rv) begin
            m_err = 1'b1;
        end
        if (acc) begin
            m_cnt[rd]++;
            m_pend++;
        end
        #1;
    endtask

    initial begin
        int live [$];
        model_reset();
        idle();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        step();
        check("reset_pending", int'(pend), 0);

        // lw x5 (long), then add x6,x5,x1 stalls until x5 retires.
        drive(1, 1, 1, 5, 1, 2, 0, 0, 0, 0);
        step();
        drive(1, 0, 1, 6, 1, 5, 1, 1, 0, 0);
        repeat (3) step();
        check("raw_stall_held", int'(stall), 1);
        drive(1, 0, 1, 6, 1, 5, 1, 1, 1, 5);
        step();
        check("raw_release_pending", int'(pend), 0);

        // Three long ops to x7, the fourth is held by the full counter.
        repeat (3) begin
            drive(1, 1, 1, 7, 0, 0, 0, 0, 0, 0);
            step();
        end
        drive(1, 1, 1, 7, 0, 0, 0, 0, 0, 0);
        step();
        check("full_pending", int'(pend), 3);
        repeat (3) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
            step();
        end

        // Long op to x0 is ignored; readers of x0 never stall.
        drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        step();
        drive(1, 0, 1, 1, 1, 0, 1, 0, 0, 0);
        step();
        check("x0_pending", int'(pend), 0);

        // x9 with one outstanding: same-cycle issue and retire cancel.
        drive(1, 1, 1, 9, 0, 0, 0, 0, 0, 0);
        step();
        drive(1, 1, 1, 9, 0, 0, 0, 0, 1, 9);
        step();
        drive(1, 0, 0, 0, 1, 9, 0, 0, 0, 0);
        step();
        check("x9_still_busy", int'(b1), 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
        step();

        // Retire to an empty x12 raises a sticky error.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 12);
        step();
        idle();
        repeat (2) step();
        check("err_sticky", int'(err), 1);

        // Asynchronous reset mid-cycle with two ops in flight.
        drive(1, 1, 1, 3, 0, 0, 0, 0, 0, 0);
        step();
        drive(1, 1, 1, 4, 0, 0, 0, 0, 0, 0);
        step();
        drive(1, 0, 1, 8, 1, 3, 1, 4, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_stall", int'(stall), 0);
        check("arst_rs1", int'(b1), 0);
        check("arst_rs2", int'(b2), 0);
        check("arst_pending", int'(pend), 0);
        check("arst_err", int'(err), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        step();
        check("post_reset_no_stall", int'(stall), 0);

        // Randomized traffic over a small register window to provoke hazards.
        for (int c = 0; c < 400; c++) begin
            bit do_rv;
            int pick;
            live.delete();
            for (int r = 1; r < 32; r++) begin
                for (int k = 0; k < m_cnt[r]; k++) live.push_back(r);
            end
            do_rv = (live.size() > 0) && ($urandom_range(0, 9) < 4);
            pick  = do_rv ? live[$urandom_range(0, live.size() - 1)] : 0;
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7), $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 7), do_rv, pick);
            step();
        end
        idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_scoreboard.md
# id_scoreboard

Register scoreboard in the ID stage. It tracks outstanding writes to architectural registers from long-latency producers: loads, multiply, divide, and anything else whose result is not available to the EX-stage forwarding network in time. It raises `stall_o` when a decoding instruction reads, or over-subscribes, a register with an unretired long-latency write. It is the producer-side complement of the EX forwarding logic: short ops resolve by forwarding, long ops resolve here.

## Interface
- `SB_CNT_SIZE`, default 2: width of each per-register outstanding-write counter (max 3 in flight per register).
- `clk` input 1: clock, all state updates on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `id_rs1_index_i` input `REG_INDEX_SIZE`: rs1 of the instruction in ID.
- `id_rs1_ren_i` input 1: instruction in ID reads rs1.
- `id_rs2_index_i` input `REG_INDEX_SIZE`: rs2 of the instruction in ID.
- `id_rs2_ren_i` input 1: instruction in ID reads rs2.
- `id_rd_index_i` input `REG_INDEX_SIZE`: rd of the instruction in ID.
- `id_rd_wen_i` input 1: instruction in ID writes rd.
- `id_long_i` input 1: instruction in ID is a long-latency producer.
- `id_issue_i` input 1: ID attempts to issue to EX this cycle.
- `retire_valid_i` input 1: a long op leaves the pipeline, either written back or killed by flush.
- `retire_rd_index_i` input `REG_INDEX_SIZE`: rd of the retiring long op.
- `stall_o` output 1: hold ID; the issue is not accepted.
- `rs1_busy_o` output 1: rs1 hazard component of the stall.
- `rs2_busy_o` output 1: rs2 hazard component of the stall.
- `pending_cnt_o` output 7: total outstanding long writes, 0..93.
- `err_o` output 1: sticky; set by a retire to a register whose count is 0, or by an overflow attempt.

## Operation
- State: 31 counters `cnt[1..31]`, each `SB_CNT_SIZE` bits; no entry for x0. Also `pending_cnt` and `err`.
- Effective count: `eff[r] = cnt[r] - (retire_valid_i & retire_rd_index_i==r)`. This is the retire bypass; the regfile writes through on the same cycle.
- `rs1_busy_o = id_rs1_ren_i & id_rs1_index_i!=0 & eff[rs1]!=0`. `rs2_busy_o` is the same for rs2.
- `full_stall = id_long_i & id_rd_wen_i & id_rd_index_i!=0 & eff[rd]==3`.
- `stall_o = id_issue_i & (rs1_busy_o | rs2_busy_o | full_stall)`.
- Accept condition: `acc = id_issue_i & ~stall_o & id_long_i & id_rd_wen_i & id_rd_index_i!=0`.
- Update: `cnt[r] += acc&(rd==r)`, `cnt[r] -= retire&(retire_rd==r)`. The net update is applied once.
  - Issue and retire to the same index in the same cycle leave the count unchanged.
- `pending_cnt` is updated by the same net rule across all registers.
- Error cases set `err`. In each case the counter is unchanged.
  - Retire with `cnt[retire_rd]==0`.
  - Retire to index 0.
- Short ops (`id_long_i=0`) never touch the table. Their hazards belong to forwarding.
- Retirement need not be in issue order across registers. Retires to the same register are counted only.

## Timing
- `stall_o`, `rs*_busy_o`: combinational from inputs and registered counters, in the same cycle.
- A long-op issue at edge N makes a dependent reader stall from cycle N+1 onward.
- A retire in cycle M releases a reader in cycle M, via the bypass.
- Reset: all `cnt=0`, `pending_cnt_o=0`, `err_o=0`. With no issue, all outputs deassert.
- Reset mid-operation clears all tracking. The pipeline is flushed by the same reset, so no retires arrive for pre-reset ops.
- `err_o` clears only on `rst`.

## Structure
- Add `SB_CNT_SIZE` and `SB_PENDING_SIZE` (7) to `defines.v`, next to `REG_INDEX_BUS`/`REG_INDEX_SIZE`.
- Sub-module `sb_entry`: one counter.
  - Inputs: inc, dec.
  - Outputs: busy, full, underflow.
  - Instantiate it 31 times via generate.
- Top-level logic: index decoders, read muxes and the pending counter.

## Test plan
- Issue `lw x5`, long, at cycle 1, then `add x6,x5,x1` in ID → `stall_o=1`, `rs1_busy_o=1` until the cycle `retire_valid_i=1, rd=5`. In that cycle `stall_o=0`, and `pending_cnt_o` goes 1→0.
- Issue three long ops to x7 with no retire, then a fourth → the fourth gets `stall_o=1` with `rs*_busy_o=0`, `cnt[7]` stays 3, `pending_cnt_o=3`.
- Long op to x0 issued, reader of x0 → no stall, `pending_cnt_o=0`.
- Same-cycle issue of a long op to x9 (`cnt[9]=1`) and retire of x9 → `cnt[9]` stays 1, `pending_cnt_o` unchanged.
- Retire to x12 with `cnt[12]=0` → `err_o=1` next cycle and sticky; counters unchanged.
- Two long ops pending, assert `rst` asynchronously mid-cycle → all outputs 0 immediately; a reader of those registers issues without stall after reset release.
